// File: rtl/lcd_bus_sequencer_if.sv
// Store/load port between the load/store unit and the LCD sequencer, plus the
// parallel HD44780-style panel pins driven by the sequencer.
interface lcd_bus_sequencer_if;
  logic        i_wr_en;
  logic [31:0] i_wdata;
  logic [31:0] o_status;
  logic        o_busy;
  logic        o_lcd_on;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic [7:0]  o_lcd_data;

  modport master (
    output i_wr_en, i_wdata,
    input  o_status, o_busy, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data
  );

  modport slave (
    input  i_wr_en, i_wdata,
    output o_status, o_busy, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// Queues stored LCD command/data words and replays them onto the panel bus with
// setup / enable / hold / execution-wait timing; reports busy and overflow status.
module lcd_bus_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic i_clk,
  input  logic i_reset,
  lcd_bus_sequencer_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, WAIT_CYC)),
                                CLR_WAIT_CYC);
  localparam int CNT_W  = $clog2(MAX_CYC) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              clr_wait;
  logic              lcd_en;
  logic              lcd_rs;
  logic [7:0]        lcd_data;
  logic              lcd_on;
  logic              overflow;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill;

  logic full;
  logic pop;
  logic wr_req;
  logic push;
  logic busy;
  logic unused_wdata;

  assign full   = (fill == FILL_W'(FIFO_DEPTH));
  assign pop    = (state == S_IDLE) && (fill != '0);
  assign wr_req = bus.i_wr_en && !bus.i_wdata[30];
  // A full FIFO still takes the word when the sequencer frees a slot on the same edge.
  assign push   = wr_req && (!full || pop);
  assign busy   = (state != S_IDLE) || (fill != '0);

  assign unused_wdata = ^bus.i_wdata[29:9];

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_wdata[8:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      lcd_on   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
      if (bus.i_wr_en) begin
        lcd_on <= bus.i_wdata[31];
        if (bus.i_wdata[30]) begin
          overflow <= 1'b0;
        end else if (full && !pop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Each state loads the down-counter with its length minus one and leaves when it hits zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      clr_wait <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {lcd_rs, lcd_data} <= mem[rd_ptr];
            clr_wait <= (mem[rd_ptr] == 9'h001) || (mem[rd_ptr] == 9'h002);
            cnt      <= CNT_W'(SETUP_CYC - 1);
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= CNT_W'(EN_CYC - 1);
            state  <= S_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= CNT_W'(HOLD_CYC - 1);
            state  <= S_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            cnt   <= clr_wait ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
            state <= S_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          lcd_en <= 1'b0;
          cnt    <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_status   = {lcd_on, 26'd0, overflow, 3'(fill), busy};
  assign bus.o_busy     = busy;
  assign bus.o_lcd_on   = lcd_on;
  assign bus.o_lcd_rs   = lcd_rs;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_en   = lcd_en;
  assign bus.o_lcd_data = lcd_data;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: a timeline model predicts every output each cycle and a
// scoreboard queue holds the words expected on each enable pulse, in order.
module tb_lcd_bus_sequencer;

  localparam int S = 2;
  localparam int E = 4;
  localparam int H = 2;
  localparam int W = 10;
  localparam int C = 30;
  localparam int D = 4;

  typedef struct {
    int         wr;
    int         pop;
    logic [8:0] word;
    int         wt;
  } entry_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  bit   checking;
  logic prev_en;

  entry_t     ents[$];
  logic [8:0] exp_q[$];
  logic       exp_on;
  logic       exp_ovf;

  lcd_bus_sequencer_if bus_if();

  lcd_bus_sequencer #(
    .FIFO_DEPTH  (D),
    .SETUP_CYC   (S),
    .EN_CYC      (E),
    .HOLD_CYC    (H),
    .WAIT_CYC    (W),
    .CLR_WAIT_CYC(C)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int occ_before(input int n);
    int k = 0;
    foreach (ents[i]) if (ents[i].wr < n && ents[i].pop >= n) k++;
    return k;
  endfunction

  function automatic bit pop_at(input int n);
    foreach (ents[i]) if (ents[i].pop == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_end();
    if (ents.size() == 0) return 0;
    return ents[$].pop + S + E + H + ents[$].wt;
  endfunction

  // Store at edge n: decide acceptance from model occupancy, then schedule the pop time.
  task automatic model_write(input int n, input logic [31:0] w);
    int p;
    entry_t e;
    exp_on = w[31];
    if (w[30]) begin
      exp_ovf = 1'b0;
    end else if (occ_before(n) == D && !pop_at(n)) begin
      exp_ovf = 1'b1;
    end else begin
      p = n + 1;
      if (ents.size() > 0 && model_end() + 1 > p) p = model_end() + 1;
      e.wr   = n;
      e.pop  = p;
      e.word = w[8:0];
      e.wt   = (w[8:0] == 9'h001 || w[8:0] == 9'h002) ? C : W;
      ents.push_back(e);
      exp_q.push_back(w[8:0]);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    int n;
    n = cyc + 1;
    bus_if.i_wr_en = 1'b1;
    bus_if.i_wdata = w;
    @(posedge clk);
    #1;
    model_write(n, w);
    bus_if.i_wr_en = 1'b0;
    bus_if.i_wdata = 32'h0;
  endtask

  task automatic applyReset(input int k);
    reset = 1'b1;
    repeat (k) begin
      @(posedge clk);
      #1;
      ents.delete();
      exp_q.delete();
      exp_on  = 1'b0;
      exp_ovf = 1'b0;
    end
    reset = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (cyc < model_end() + 2 && guard < 2000) begin
      idle(1);
      guard++;
    end
  endtask

  // Monitor: full output prediction every cycle; scoreboard pop on each EN rising edge.
  always @(negedge clk) begin
    int         t;
    int         cnt;
    bit         active;
    bit         en;
    int         last_pop;
    logic [8:0] busw;
    logic [8:0] head;
    if (checking) begin
      t        = cyc;
      cnt      = 0;
      active   = 1'b0;
      en       = 1'b0;
      last_pop = -1;
      busw     = 9'h000;
      foreach (ents[i]) begin
        if (ents[i].wr <= t && ents[i].pop > t) cnt++;
        if (ents[i].pop <= t && t < ents[i].pop + S + E + H + ents[i].wt) active = 1'b1;
        if (ents[i].pop + S <= t && t < ents[i].pop + S + E) en = 1'b1;
        if (ents[i].pop <= t && ents[i].pop > last_pop) begin
          last_pop = ents[i].pop;
          busw     = ents[i].word;
        end
      end
      checkOutput("status", bus_if.o_status,
                  {exp_on, 26'd0, exp_ovf, 3'(cnt), (active || cnt != 0)});
      checkOutput("busy", 32'(bus_if.o_busy), 32'(active || cnt != 0));
      checkOutput("lcd_on", 32'(bus_if.o_lcd_on), 32'(exp_on));
      checkOutput("lcd_en", 32'(bus_if.o_lcd_en), 32'(en));
      checkOutput("lcd_rs_data", 32'({bus_if.o_lcd_rs, bus_if.o_lcd_data}), 32'(busw));
      checkOutput("lcd_rw", 32'(bus_if.o_lcd_rw), 32'd0);
      if (bus_if.o_lcd_en === 1'b1 && prev_en !== 1'b1) begin
        checkOutput("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          checkOutput("sb_word", 32'({bus_if.o_lcd_rs, bus_if.o_lcd_data}), 32'(head));
        end
      end
    end
    prev_en = bus_if.o_lcd_en;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target;
    int guard;
    logic [31:0] w;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    checking = 1'b0;
    prev_en  = 1'b0;
    exp_on   = 1'b0;
    exp_ovf  = 1'b0;
    reset    = 1'b0;
    bus_if.i_wr_en = 1'b0;
    bus_if.i_wdata = 32'h0;
    @(posedge clk);
    #1;
    applyReset(3);
    checking = 1'b1;
    idle(2);

    applyStimulus(32'h8000_0141);
    idle(25);

    applyStimulus(32'h0000_0001);
    idle(45);
    applyStimulus(32'h0000_0003);
    idle(25);

    // Overflow: one word starts the sequencer, five more overfill the queue.
    applyStimulus(32'h8000_0130);
    for (int i = 1; i <= 5; i++) applyStimulus(32'h8000_0130 + 32'(i));
    idle(2);
    applyStimulus(32'h4000_0000);
    idle(1);

    // Full queue: write on the exact edge the sequencer pops.
    target = 0;
    foreach (ents[i]) if (ents[i].pop >= cyc + 1 && (target == 0 || ents[i].pop < target))
      target = ents[i].pop;
    guard = 0;
    while (cyc + 1 < target && guard < 200) begin
      idle(1);
      guard++;
    end
    applyStimulus(32'h8000_0136);
    drain();

    applyStimulus(32'h8000_0148);
    idle(3);
    applyReset(1);
    idle(30);

    for (int i = 0; i < 40; i++) begin
      w = 32'h0;
      w[31] = 1'($urandom_range(0, 1));
      w[30] = ($urandom_range(0, 9) == 0);
      w[8]  = 1'($urandom_range(0, 1));
      w[7:0] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        w[8]   = 1'b0;
        w[7:0] = 8'($urandom_range(1, 2));
      end
      w[29:9] = 21'($urandom);
      applyStimulus(w);
      idle($urandom_range(0, 25));
    end
    drain();
    idle(3);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
